// File: rtl/preg_alloc_ctrl.sv
// Physical-register allocation controller: sizes int/FP freelist reads, grants whole
// rename groups, steers compacted freelist heads to slots and sequences redirect/walk.
module preg_alloc_lane #(
  parameter int FETCH_WIDTH = 4,
  parameter int PREG_WIDTH  = 7,
  parameter int CNT_W       = $clog2(FETCH_WIDTH) + 1,
  parameter int LANE        = 0
) (
  input  logic [FETCH_WIDTH-1:0]            int_we,
  input  logic [FETCH_WIDTH-1:0]            fp_we,
  input  logic [FETCH_WIDTH*PREG_WIDTH-1:0] int_prd,
  input  logic [FETCH_WIDTH*PREG_WIDTH-1:0] fp_prd,
  output logic [PREG_WIDTH-1:0]             prd
);
  logic [CNT_W-1:0] ki, kf;

  // Each slot picks the freelist entry indexed by how many same-class slots sit below it.
  always_comb begin
    ki = '0;
    kf = '0;
    for (int j = 0; j < LANE; j++) begin
      ki = ki + CNT_W'(int_we[j]);
      kf = kf + CNT_W'(fp_we[j]);
    end
    prd = '0;
    if (int_we[LANE])     prd = int_prd[int'(ki)*PREG_WIDTH +: PREG_WIDTH];
    else if (fp_we[LANE]) prd = fp_prd[int'(kf)*PREG_WIDTH +: PREG_WIDTH];
  end
endmodule

module preg_alloc_ctrl #(
  parameter int FETCH_WIDTH = 4,
  parameter int PREG_WIDTH  = 7,
  parameter int CNT_W       = $clog2(FETCH_WIDTH) + 1,
  parameter int PERF_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  input  logic [FETCH_WIDTH-1:0]            req_int_we,
  input  logic [FETCH_WIDTH-1:0]            req_fp_we,
  output logic                              req_ready,
  output logic [CNT_W-1:0]                  int_rd_num,
  input  logic [FETCH_WIDTH*PREG_WIDTH-1:0] int_prd,
  input  logic                              int_full,
  output logic [CNT_W-1:0]                  fp_rd_num,
  input  logic [FETCH_WIDTH*PREG_WIDTH-1:0] fp_prd,
  input  logic                              fp_full,
  output logic                              alloc_hold,
  input  logic                              redirect,
  input  logic                              walk_done,
  output logic                              out_valid,
  output logic [FETCH_WIDTH*PREG_WIDTH-1:0] out_prd,
  input  logic                              out_ready,
  output logic [PERF_W-1:0]                 int_stall_cnt,
  output logic [PERF_W-1:0]                 fp_stall_cnt
);
  typedef enum logic {NORMAL, WALK} state_t;

  state_t state;
  logic active, space, fire;
  logic [CNT_W-1:0] int_cnt, fp_cnt;
  logic [FETCH_WIDTH-1:0][PREG_WIDTH-1:0] lane_prd;

  always_comb begin
    int_cnt = '0;
    fp_cnt  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      int_cnt = int_cnt + CNT_W'(req_int_we[i]);
      fp_cnt  = fp_cnt  + CNT_W'(req_fp_we[i]);
    end
  end

  // Counts deliberately ignore the full flags so the freelists see no loop through us.
  assign active     = req_valid & (state == NORMAL);
  assign int_rd_num = active ? int_cnt : '0;
  assign fp_rd_num  = active ? fp_cnt  : '0;
  assign space      = ~out_valid | out_ready;
  assign fire       = active & ~redirect & ~int_full & ~fp_full & space;
  assign req_ready  = fire;
  assign alloc_hold = ~fire;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    preg_alloc_lane #(
      .FETCH_WIDTH(FETCH_WIDTH), .PREG_WIDTH(PREG_WIDTH), .CNT_W(CNT_W), .LANE(g)
    ) u_lane (
      .int_we (req_int_we),
      .fp_we  (req_fp_we),
      .int_prd(int_prd),
      .fp_prd (fp_prd),
      .prd    (lane_prd[g])
    );
  end

  // redirect outranks walk_done so a fresh flush is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 state <= NORMAL;
    else if (redirect)                       state <= WALK;
    else if (state == WALK && walk_done)     state <= NORMAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prd   <= '0;
    end else if (redirect) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_prd   <= lane_prd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_stall_cnt <= '0;
      fp_stall_cnt  <= '0;
    end else if (active & space) begin
      if (int_full && int_stall_cnt != '1) int_stall_cnt <= int_stall_cnt + 1'b1;
      if (fp_full  && fp_stall_cnt  != '1) fp_stall_cnt  <= fp_stall_cnt  + 1'b1;
    end
  end
endmodule
